pc_register: RTL and testbench
==============================

Name: pc_register

Overview:
- Program-counter register for the simple teaching CPU datapath; supplies the instruction-fetch address every clock.
- Holds an 8-bit address that loads a fixed start address on reset and advances by a fixed step on every non-reset clock edge.
- Sits between the clock/reset source and the instruction-memory address input.
- Only clk, rst and pcAddr are required connections; all other outputs are optional observation outputs and may be left unconnected.

Parameters:
- WIDTH, 8, address width in bits.
- RESET_ADDR, 8'h80 (8'b1000_0000), address loaded on reset and at power-up.
- STEP, 1, increment applied per non-reset clock edge.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pcAddr  output  WIDTH  current program-counter value (registered).
- pcNext  output  WIDTH  value pcAddr takes at the next edge if rst is low; combinational, (pcAddr + STEP) mod 2^WIDTH.
- wrapped  output  1  registered one-cycle pulse, high for the cycle after the increment carried out of WIDTH bits.
- fetchCount  output  16  registered count of non-reset advances since the last reset; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk. A rst pulse that does not span a rising edge has no effect.
- Power-up: pcAddr = RESET_ADDR, wrapped = 0 and fetchCount = 0 through register initial values, so pcAddr is never X before the first reset.
- Reset edge (rst = 1): pcAddr <= RESET_ADDR, wrapped <= 0, fetchCount <= 0.
- Reset priority: reset has priority over the increment.
- Reset mid-run: takes effect at the next rising edge regardless of the current value.
- Reset held high: pcAddr stays at RESET_ADDR on every edge.
- Normal edge (rst = 0):
  - pcAddr <= pcNext.
  - wrapped <= carry-out of (pcAddr + STEP) beyond WIDTH bits.
  - fetchCount <= fetchCount + 1, unless it is already 16'hFFFF.
- Latency: one cycle from the rst or advance edge to the new pcAddr; pcNext has zero latency.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - 8'hFF + 1 -> 8'h00, with wrapped high for one cycle.
  - No other saturation or stall on pcAddr.
- Release from reset: the first edge with rst = 0 gives pcAddr = RESET_ADDR + STEP (8'h81 with defaults).
- Combinational rules: no combinational path from rst to any output except through pcNext, which depends only on pcAddr. There are no latches.

Test Plan:
- Power-up, no reset asserted, before the first edge -> pcAddr = 8'h80, pcNext = 8'h81, fetchCount = 0.
- rst = 1 for 2 edges, then rst = 0 for 3 edges -> pcAddr = 80, 80, 81, 82, 83; fetchCount = 0, 0, 1, 2, 3.
- Reset mid-run: advance to 8'h85, assert rst for 1 edge -> pcAddr = 8'h80 and fetchCount = 0 on that edge; resumes at 8'h81.
- Wrap: run from reset for 127 advances -> pcAddr = 8'hFF and pcNext = 8'h00; the next edge gives pcAddr = 8'h00 with wrapped = 1 for exactly one cycle, then pcAddr = 8'h01 with wrapped = 0.
- rst toggled between edges (high 5 ns, entirely within the low clock phase) -> no reset; pcAddr continues incrementing.
- Parameter variant STEP = 4, RESET_ADDR = 8'h00 -> sequence after reset is 00, 04, 08, ...; the advance from FC goes to 00 with wrapped = 1.

Source files
------------

// File: rtl/pc_register.sv
// Program-counter register for the teaching CPU datapath.
// Holds the instruction-fetch address: loads RESET_ADDR on a synchronous
// reset and otherwise advances by STEP (modulo 2^WIDTH) on every rising
// edge. Also exposes the combinational next address, a one-cycle wrap pulse
// and a saturating count of advances since the last reset.
module pc_register #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(8'h80),
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] pcAddr,
  output logic [WIDTH-1:0] pcNext,
  output logic             wrapped,
  output logic [15:0]      fetchCount
);

  // Saturating increment for the advance counter: sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    r = (v == 16'hFFFF) ? v : v + 16'd1;
    return r;
  endfunction

  // Register initial values give defined outputs before the first reset.
  logic [WIDTH-1:0] pc_q    = RESET_ADDR;
  logic             wrap_q  = 1'b0;
  logic [15:0]      count_q = 16'd0;

  // One extra bit captures the carry out of the address add.
  logic [WIDTH:0]   sum;

  // Next-address adder; depends only on the current address.
  always_comb begin
    sum = {1'b0, pc_q} + {1'b0, STEP};
  end

  // Address, wrap flag and advance counter; reset wins over advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_ADDR;
      wrap_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      pc_q    <= sum[WIDTH-1:0];
      wrap_q  <= sum[WIDTH];
      count_q <= sat_inc(count_q);
    end
  end

  assign pcAddr     = pc_q;
  assign pcNext     = sum[WIDTH-1:0];
  assign wrapped    = wrap_q;
  assign fetchCount = count_q;

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: default instance plus a
// STEP=4 / RESET_ADDR=0 variant sharing the same clock.
module tb_pc_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_v = 1'b1;

  logic [7:0]  pc_addr, pc_next;
  logic        wrapped;
  logic [15:0] fetch_count;

  logic [7:0]  v_pc_addr, v_pc_next;
  logic        v_wrapped;
  logic [15:0] v_fetch_count;

  int checks = 0;
  int failures = 0;

  // Reference model state for the default instance: number of advances
  // since the last reset and whether the most recent edge was an advance.
  longint cnt = 0;
  bit     last_adv = 0;

  pc_register dut (
    .clk        (clk),
    .rst        (rst),
    .pcAddr     (pc_addr),
    .pcNext     (pc_next),
    .wrapped    (wrapped),
    .fetchCount (fetch_count)
  );

  pc_register #(.WIDTH(8), .RESET_ADDR(8'h00), .STEP(8'd4)) dut_v (
    .clk        (clk),
    .rst        (rst_v),
    .pcAddr     (v_pc_addr),
    .pcNext     (v_pc_next),
    .wrapped    (v_wrapped),
    .fetchCount (v_fetch_count)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        r;
    logic [7:0]  pc;
    logic [7:0]  nx;
    logic        wr;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_pc();
    return 8'((128 + cnt) % 256);
  endfunction

  function automatic logic m_wrap();
    return last_adv && (((128 + cnt) / 256) != ((128 + cnt - 1) / 256));
  endfunction

  function automatic logic [15:0] m_fc();
    return (cnt > 65535) ? 16'hFFFF : 16'(cnt);
  endfunction

  task automatic model_edge(input logic r);
    if (r) begin
      cnt = 0;
      last_adv = 0;
    end else begin
      cnt++;
      last_adv = 1;
    end
  endtask

  task automatic check_main(input string tag);
    chk({tag, ".pcAddr"}, 32'(pc_addr), 32'(m_pc()));
    chk({tag, ".pcNext"}, 32'(pc_next), 32'(8'(m_pc() + 8'd1)));
    chk({tag, ".wrapped"}, 32'(wrapped), 32'(m_wrap()));
    chk({tag, ".fetchCount"}, 32'(fetch_count), 32'(m_fc()));
  endtask

  // Drive both resets, take one rising edge, sample 1 ns after it.
  task automatic step(input logic r, input logic rv);
    rst = r;
    rst_v = rv;
    @(posedge clk);
    #1;
    model_edge(r);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h80, 8'h81, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 8'h80, 8'h81, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 8'h81, 8'h82, 1'b0, 16'd1};
    tbl[3] = '{1'b0, 8'h82, 8'h83, 1'b0, 16'd2};
    tbl[4] = '{1'b0, 8'h83, 8'h84, 1'b0, 16'd3};
    tbl[5] = '{1'b0, 8'h84, 8'h85, 1'b0, 16'd4};
    tbl[6] = '{1'b0, 8'h85, 8'h86, 1'b0, 16'd5};
    tbl[7] = '{1'b1, 8'h80, 8'h81, 1'b0, 16'd0};
    tbl[8] = '{1'b0, 8'h81, 8'h82, 1'b0, 16'd1};

    // Power-up values before any edge.
    #1;
    chk("pwr.pcAddr", 32'(pc_addr), 32'h80);
    chk("pwr.pcNext", 32'(pc_next), 32'h81);
    chk("pwr.wrapped", 32'(wrapped), 32'h0);
    chk("pwr.fetchCount", 32'(fetch_count), 32'h0);
    chk("pwr.v.pcAddr", 32'(v_pc_addr), 32'h00);
    chk("pwr.v.pcNext", 32'(v_pc_next), 32'h04);

    // Table: reset for two edges, advance, reset mid-run at 0x85, resume.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, 1'b1);
      chk($sformatf("tbl%0d.pcAddr", i), 32'(pc_addr), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d.pcNext", i), 32'(pc_next), 32'(tbl[i].nx));
      chk($sformatf("tbl%0d.wrapped", i), 32'(wrapped), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d.fetchCount", i), 32'(fetch_count), 32'(tbl[i].fc));
    end

    // Wrap: 127 advances from reset reach 0xFF, then one-cycle pulse.
    step(1'b1, 1'b1);
    for (int i = 0; i < 127; i++) step(1'b0, 1'b1);
    chk("wrap.pcAddr_ff", 32'(pc_addr), 32'hFF);
    chk("wrap.pcNext_00", 32'(pc_next), 32'h00);
    chk("wrap.pre_wrapped", 32'(wrapped), 32'h0);
    step(1'b0, 1'b1);
    chk("wrap.pcAddr_00", 32'(pc_addr), 32'h00);
    chk("wrap.wrapped_hi", 32'(wrapped), 32'h1);
    step(1'b0, 1'b1);
    chk("wrap.pcAddr_01", 32'(pc_addr), 32'h01);
    chk("wrap.wrapped_lo", 32'(wrapped), 32'h0);
    check_main("wrap.model");

    // Reset pulses confined to the low clock phase must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #5 rst = 1'b0;
      @(posedge clk);
      #1;
      model_edge(1'b0);
      check_main($sformatf("glitch%0d", i));
    end

    // Randomized reset/advance traffic against the arithmetic model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 16) == 0, 1'b1);
      check_main($sformatf("rnd%0d", i));
    end

    // Variant: STEP=4 from address 0; advance from 0xFC wraps to 0x00.
    step(1'b0, 1'b1);
    chk("var.rst.pcAddr", 32'(v_pc_addr), 32'h00);
    chk("var.rst.fetchCount", 32'(v_fetch_count), 32'h0);
    for (int k = 1; k <= 66; k++) begin
      step(1'b0, 1'b0);
      chk($sformatf("var%0d.pcAddr", k), 32'(v_pc_addr), 32'((4 * k) % 256));
      chk($sformatf("var%0d.pcNext", k), 32'(v_pc_next), 32'((4 * k + 4) % 256));
      chk($sformatf("var%0d.wrapped", k), 32'(v_wrapped), 32'(k == 64));
      chk($sformatf("var%0d.fetchCount", k), 32'(v_fetch_count), 32'(k));
    end
    check_main("var.main");

    // Saturation: advance well past 65535 counts since the last reset.
    step(1'b1, 1'b1);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1);
    check_main("sat");
    step(1'b0, 1'b1);
    check_main("sat.hold");
    step(1'b1, 1'b1);
    check_main("sat.reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
